disp_decode: RTL and testbench

DISP_DECODE -- requirements
Module: disp_decode

---
 rtl/disp_decode.sv | 151 +++++++++++++++
 tb/tb_disp_decode.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/disp_decode.sv
// Multiplexed 7-segment display decoder: debounces the seg/dig bus, decodes each
// stable digit to BCD and tracks per-digit valid/dp, frame completion and error flags.
module disp_decode #(
   parameter int unsigned STABLE_CYC = 4
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_clr,
   input  logic [7:0]  i_seg,
   input  logic [7:0]  i_dig,
   output logic [31:0] o_digits,
   output logic [7:0]  o_dp_out,
   output logic [7:0]  o_valid,
   output logic        o_upd,
   output logic [2:0]  o_upd_idx,
   output logic        o_frame,
   output logic [1:0]  o_err
);

   localparam logic [7:0] CntMax = 8'(STABLE_CYC);
   localparam logic [7:0] CntCap = 8'(STABLE_CYC - 1);

   typedef enum logic [1:0] {StSettle, StCapture, StHold} state_t;

   logic [7:0]  r_seg, r_dig;
   logic [7:0]  r_cnt, w_cnt_d;
   state_t      r_state, w_state_d;
   logic [31:0] r_digits;
   logic [7:0]  r_dp_out, r_valid, r_mask, w_mask_d;
   logic        r_upd, r_frame;
   logic [2:0]  r_upd_idx;
   logic [1:0]  r_err;

   logic        w_same, w_cap, w_upd_now;
   logic [3:0]  w_code;
   logic        w_legal, w_blank;
   logic [2:0]  w_dig_idx;
   logic [3:0]  w_dig_cnt;

   assign w_same = ({i_seg, i_dig} == {r_seg, r_dig});
   // Capture on the edge where the counter steps from STABLE_CYC-1 to STABLE_CYC.
   assign w_cap     = !i_clr && w_same && (r_state == StSettle) && (r_cnt == CntCap);
   assign w_upd_now = w_cap && (w_dig_cnt == 4'd1);

   always_comb begin
      w_cnt_d   = r_cnt;
      w_state_d = r_state;
      if (i_clr || !w_same) begin
         w_cnt_d   = 8'd1;
         w_state_d = StSettle;
      end else begin
         if (r_cnt != CntMax) w_cnt_d = r_cnt + 8'd1;
         if (w_cap) w_state_d = StCapture;
         else if (r_state == StCapture) w_state_d = StHold;
      end
   end

   always_comb begin
      w_code  = 4'hF;
      w_legal = 1'b0;
      w_blank = 1'b0;
      case (r_seg[7:1])
         7'h7E: begin w_code = 4'd0; w_legal = 1'b1; end
         7'h30: begin w_code = 4'd1; w_legal = 1'b1; end
         7'h6D: begin w_code = 4'd2; w_legal = 1'b1; end
         7'h79: begin w_code = 4'd3; w_legal = 1'b1; end
         7'h33: begin w_code = 4'd4; w_legal = 1'b1; end
         7'h5B: begin w_code = 4'd5; w_legal = 1'b1; end
         7'h5F: begin w_code = 4'd6; w_legal = 1'b1; end
         7'h70: begin w_code = 4'd7; w_legal = 1'b1; end
         7'h7F: begin w_code = 4'd8; w_legal = 1'b1; end
         7'h7B: begin w_code = 4'd9; w_legal = 1'b1; end
         7'h00: w_blank = 1'b1;
         default: ;
      endcase
   end

   always_comb begin
      w_dig_idx = 3'd0;
      w_dig_cnt = 4'd0;
      for (int i = 0; i < 8; i++) begin
         if (r_dig[i]) begin
            w_dig_idx = 3'(i);
            w_dig_cnt = w_dig_cnt + 4'd1;
         end
      end
   end

   // A full mask is cleared on the cycle frame is raised.
   always_comb begin
      w_mask_d = (&r_mask) ? 8'd0 : r_mask;
      if (w_upd_now) w_mask_d = w_mask_d | r_dig;
      if (i_clr) w_mask_d = 8'd0;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_seg   <= 8'd0;
         r_dig   <= 8'd0;
         r_cnt   <= 8'd0;
         r_state <= StSettle;
      end else begin
         r_seg   <= i_seg;
         r_dig   <= i_dig;
         r_cnt   <= w_cnt_d;
         r_state <= w_state_d;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_digits  <= 32'd0;
         r_dp_out  <= 8'd0;
         r_valid   <= 8'd0;
         r_err     <= 2'd0;
         r_upd     <= 1'b0;
         r_upd_idx <= 3'd0;
         r_frame   <= 1'b0;
         r_mask    <= 8'd0;
      end else begin
         r_mask  <= w_mask_d;
         r_upd   <= w_upd_now;
         r_frame <= !i_clr && (&r_mask);
         if (i_clr) begin
            r_digits <= 32'd0;
            r_dp_out <= 8'd0;
            r_valid  <= 8'd0;
            r_err    <= 2'd0;
         end else if (w_cap) begin
            if (w_dig_cnt > 4'd1) begin
               r_err[1] <= 1'b1;
            end else if (w_upd_now) begin
               r_upd_idx                      <= w_dig_idx;
               r_digits[{w_dig_idx, 2'b00} +: 4] <= w_legal ? w_code : 4'hF;
               r_dp_out[w_dig_idx]            <= r_seg[0];
               r_valid[w_dig_idx]             <= w_legal;
               if (!w_legal && !w_blank) r_err[0] <= 1'b1;
            end
         end
      end
   end

   assign o_digits  = r_digits;
   assign o_dp_out  = r_dp_out;
   assign o_valid   = r_valid;
   assign o_upd     = r_upd;
   assign o_upd_idx = r_upd_idx;
   assign o_frame   = r_frame;
   assign o_err     = r_err;

endmodule

// File: tb/tb_disp_decode.sv
// Self-checking bench for disp_decode: directed scenarios plus randomized bus traffic
// compared cycle by cycle against a run-length based behavioural model.
module tb_disp_decode;
   localparam int unsigned STABLE = 4;

   logic        clk = 1'b0, rst_n = 1'b0, clr = 1'b0;
   logic [7:0]  seg = 8'd0, dig = 8'd0;
   logic [31:0] o_digits;
   logic [7:0]  o_dp_out, o_valid;
   logic        o_upd, o_frame;
   logic [2:0]  o_upd_idx;
   logic [1:0]  o_err;

   disp_decode #(.STABLE_CYC(STABLE)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_clr(clr), .i_seg(seg), .i_dig(dig),
      .o_digits(o_digits), .o_dp_out(o_dp_out), .o_valid(o_valid), .o_upd(o_upd),
      .o_upd_idx(o_upd_idx), .o_frame(o_frame), .o_err(o_err)
   );

   always #5 clk = ~clk;

   int n_run = 0, n_fail = 0;
   logic [7:0] seg_tab [10] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66,
                                8'hB6, 8'hBE, 8'hE0, 8'hFE, 8'hF6};

   // Model: bus value, cycles it has been held, and displayed state.
   logic [15:0] m_in;
   int          m_run;
   logic [3:0]  m_dig [8];
   logic [7:0]  m_dp, m_valid, m_seen;
   logic [1:0]  m_err;
   logic        m_upd, m_frame, m_pend;
   logic [2:0]  m_idx;
   int          cyc, upd_cnt, frame_cnt, last_upd_cyc, frame_cyc;

   function automatic int decode(input logic [7:0] s);
      logic [7:0] t;
      for (int k = 0; k < 10; k++) begin
         t = seg_tab[k];
         if ((s & 8'hFE) == t) return k;
      end
      if ((s & 8'hFE) == 8'h00) return 10;
      return 11;
   endfunction

   function automatic logic [51:0] exp_vec();
      logic [31:0] d;
      for (int i = 0; i < 8; i++) d[i*4 +: 4] = m_dig[i];
      return {d, m_dp, m_valid, m_upd, m_frame, m_err};
   endfunction

   function automatic logic [51:0] dut_vec();
      return {o_digits, o_dp_out, o_valid, o_upd, o_frame, o_err};
   endfunction

   task automatic model_reset();
      m_in = 16'd0; m_run = 0; m_dp = 8'd0; m_valid = 8'd0; m_seen = 8'd0;
      m_err = 2'd0; m_upd = 1'b0; m_frame = 1'b0; m_pend = 1'b0; m_idx = 3'd0;
      for (int i = 0; i < 8; i++) m_dig[i] = 4'd0;
   endtask

   task automatic model_edge(input logic [7:0] s, input logic [7:0] d, input logic c);
      logic [15:0] nv;
      int code, idx;
      nv = {s, d};
      if (c) begin
         model_reset();
         m_in = nv; m_run = 1;
         return;
      end
      m_frame = m_pend;
      if (m_pend) begin m_seen = 8'd0; m_pend = 1'b0; end
      m_run = (nv == m_in) ? m_run + 1 : 1;
      m_in  = nv;
      m_upd = 1'b0;
      if (m_run == STABLE) begin
         if ($countones(d) > 1) m_err[1] = 1'b1;
         else if (d != 8'd0) begin
            idx = 0;
            for (int i = 0; i < 8; i++) if (d[i]) idx = i;
            code = decode(s);
            m_upd = 1'b1; m_idx = 3'(idx);
            m_dig[idx]   = (code < 10) ? 4'(code) : 4'hF;
            m_valid[idx] = (code < 10);
            m_dp[idx]    = s[0];
            if (code == 11) m_err[0] = 1'b1;
            m_seen[idx] = 1'b1;
            if (m_seen == 8'hFF) m_pend = 1'b1;
         end
      end
   endtask

   task automatic step(input logic [7:0] s, input logic [7:0] d, input logic c);
      seg = s; dig = d; clr = c;
      @(posedge clk);
      model_edge(s, d, c);
      #1;
      cyc++;
      if (o_upd) begin upd_cnt++; last_upd_cyc = cyc; end
      if (o_frame) begin frame_cnt++; frame_cyc = cyc; end
   endtask

   task automatic do_reset();
      seg = 8'd0; dig = 8'd0; clr = 1'b0;
      rst_n = 1'b0;
      model_reset();
      @(posedge clk);
      #1 rst_n = 1'b1;
      upd_cnt = 0; frame_cnt = 0; last_upd_cyc = -1; frame_cyc = -1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #1;
      n_run++;
      if (dut_vec() !== 52'd0 || o_upd_idx !== 3'd0) begin
         n_fail++;
         $display("FAIL reset_state got=%h idx=%0d want=0", dut_vec(), o_upd_idx);
      end
      do_reset();
   endtask

   task automatic test_single();
      do_reset();
      for (int i = 0; i < 10; i++) begin
         step(8'hDA, 8'h04, 1'b0);
         n_run++;
         if (dut_vec() !== exp_vec() || (o_upd && o_upd_idx !== 3'd2)) begin
            n_fail++;
            $display("FAIL single_cyc%0d got=%h idx=%0d want=%h", i, dut_vec(), o_upd_idx,
                     exp_vec());
         end
      end
      n_run++;
      if (upd_cnt != 1 || o_digits[11:8] !== 4'd2 || o_valid[2] !== 1'b1 || o_dp_out[2] !== 1'b0)
      begin
         n_fail++;
         $display("FAIL single_result upd=%0d nib=%h v=%b dp=%b want 1/2/1/0", upd_cnt,
                  o_digits[11:8], o_valid[2], o_dp_out[2]);
      end
   endtask

   task automatic test_partial();
      do_reset();
      for (int i = 0; i < 8; i++) begin
         step((i < 3) ? 8'h60 : 8'hF2, 8'h01, 1'b0);
         n_run++;
         if (dut_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL partial_cyc%0d got=%h want=%h", i, dut_vec(), exp_vec());
         end
      end
      n_run++;
      if (upd_cnt != 1 || o_digits[3:0] !== 4'd3) begin
         n_fail++;
         $display("FAIL partial_result upd=%0d nib0=%h want 1/3", upd_cnt, o_digits[3:0]);
      end
   endtask

   task automatic test_sweep();
      do_reset();
      for (int k = 0; k < 8; k++) begin
         for (int j = 0; j < 4; j++) begin
            step(seg_tab[k], 8'(1 << k), 1'b0);
            n_run++;
            if (dut_vec() !== exp_vec() || (o_upd && o_upd_idx !== 3'(k))) begin
               n_fail++;
               $display("FAIL sweep_d%0d_c%0d got=%h idx=%0d want=%h", k, j, dut_vec(),
                        o_upd_idx, exp_vec());
            end
         end
      end
      step(seg_tab[7], 8'h80, 1'b0);
      step(seg_tab[7], 8'h80, 1'b0);
      n_run++;
      if (o_digits !== 32'h76543210 || o_valid !== 8'hFF || upd_cnt != 8 || frame_cnt != 1 ||
          frame_cyc != last_upd_cyc + 1) begin
         n_fail++;
         $display("FAIL sweep_result dig=%h v=%h upd=%0d fr=%0d frc=%0d lastupd=%0d",
                  o_digits, o_valid, upd_cnt, frame_cnt, frame_cyc, last_upd_cyc);
      end
   endtask

   task automatic test_errors();
      do_reset();
      for (int i = 0; i < 4; i++) step(8'h12, 8'h08, 1'b0);
      n_run++;
      if (o_err !== 2'b01 || o_valid[3] !== 1'b0 || o_digits[15:12] !== 4'hF) begin
         n_fail++;
         $display("FAIL err_illegal err=%b v3=%b nib3=%h want 01/0/F", o_err, o_valid[3],
                  o_digits[15:12]);
      end
      upd_cnt = 0;
      for (int i = 0; i < 4; i++) step(8'h12, 8'h03, 1'b0);
      n_run++;
      if (o_err !== 2'b11 || upd_cnt != 0 || dut_vec() !== exp_vec()) begin
         n_fail++;
         $display("FAIL err_multi err=%b upd=%0d want 11/0", o_err, upd_cnt);
      end
      step(8'h12, 8'h03, 1'b1);
      n_run++;
      if (o_err !== 2'b00 || o_digits !== 32'd0 || dut_vec() !== exp_vec()) begin
         n_fail++;
         $display("FAIL err_clear err=%b dig=%h want 00/0", o_err, o_digits);
      end
   endtask

   task automatic test_blank();
      do_reset();
      for (int i = 0; i < 4; i++) step(8'h00, 8'h10, 1'b0);
      n_run++;
      if (upd_cnt != 1 || o_digits[19:16] !== 4'hF || o_valid[4] !== 1'b0 || o_err !== 2'b00)
      begin
         n_fail++;
         $display("FAIL blank upd=%0d nib4=%h v4=%b err=%b want 1/F/0/00", upd_cnt,
                  o_digits[19:16], o_valid[4], o_err);
      end
      for (int i = 0; i < 4; i++) step(8'hF7, 8'h10, 1'b0);
      n_run++;
      if (o_digits[19:16] !== 4'd9 || o_dp_out[4] !== 1'b1 || o_valid[4] !== 1'b1) begin
         n_fail++;
         $display("FAIL nine_dp nib4=%h dp4=%b v4=%b want 9/1/1", o_digits[19:16],
                  o_dp_out[4], o_valid[4]);
      end
   endtask

   task automatic test_reset_midwindow();
      int upd_at;
      do_reset();
      for (int i = 0; i < 3; i++) step(8'hB6, 8'h20, 1'b0);
      rst_n = 1'b0;
      model_reset();
      #1;
      n_run++;
      if (dut_vec() !== 52'd0) begin
         n_fail++;
         $display("FAIL midrst_async got=%h want=0", dut_vec());
      end
      @(posedge clk);
      #1;
      n_run++;
      if (dut_vec() !== 52'd0) begin
         n_fail++;
         $display("FAIL midrst_hold got=%h want=0", dut_vec());
      end
      rst_n = 1'b1;
      upd_at = -1;
      for (int i = 1; i <= 6; i++) begin
         step(8'hB6, 8'h20, 1'b0);
         if (o_upd && upd_at < 0) upd_at = i;
         n_run++;
         if (dut_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL midrst_cyc%0d got=%h want=%h", i, dut_vec(), exp_vec());
         end
      end
      n_run++;
      if (upd_at != 4) begin
         n_fail++;
         $display("FAIL midrst_latency got=%0d want=4", upd_at);
      end
   endtask

   task automatic test_random();
      logic [7:0] s, d;
      int hold;
      do_reset();
      s = 8'd0; d = 8'd0;
      for (int n = 0; n < 300; n++) begin
         case ($urandom_range(0, 9))
            0, 1, 2, 3, 4, 5, 6: s = seg_tab[$urandom_range(0, 9)] | 8'($urandom_range(0, 1));
            7:                   s = 8'($urandom_range(0, 1));
            8:                   s = 8'($urandom);
            default:             ;
         endcase
         case ($urandom_range(0, 9))
            0:       d = 8'd0;
            1:       d = 8'($urandom);
            default: d = 8'(1 << $urandom_range(0, 7));
         endcase
         hold = $urandom_range(1, 6);
         for (int h = 0; h < hold; h++) begin
            step(s, d, ($urandom_range(0, 39) == 0));
            n_run++;
            if (dut_vec() !== exp_vec() || (m_upd && o_upd_idx !== m_idx)) begin
               n_fail++;
               $display("FAIL random_n%0d got=%h idx=%0d want=%h idx=%0d", n, dut_vec(),
                        o_upd_idx, exp_vec(), m_idx);
            end
         end
      end
   endtask

   initial begin
      cyc = 0;
      model_reset();
      test_reset();
      test_single();
      test_partial();
      test_sweep();
      test_errors();
      test_blank();
      test_reset_midwindow();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
